coin_stream_encoder: RTL and testbench

Serializes coin-insertion events into the single-bit coin stream `x` that the vending-machine controller `vm` samples. It is the transmitter end of the `x` link and replaces the behavioural stimulus source with synthesizable RTL. Coin codes enter through a valid/ready port and are buffered in a small FIFO. Each code is then sent on `x` as a framed serial word.

---
 rtl/coin_pkg.sv | 19 +
 rtl/coin_stream_encoder_if.sv | 13 +
 rtl/coin_fifo.sv | 56 +++++
 rtl/coin_stream_encoder.sv | 162 ++++++++++++++++
 tb/tb_coin_stream_encoder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/coin_pkg.sv
// Shared definitions for the coin stream encoder: FSM states, coin codes, default code width.
package coin_pkg;

    localparam int COIN_BITS_DEFAULT = 2;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_25   = 2'd1;
    localparam logic [1:0] COIN_50   = 2'd2;
    localparam logic [1:0] COIN_100  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        GAP    = 3'd4
    } coin_state_e;

endpackage

// File: rtl/coin_stream_encoder_if.sv
// Coin-code offer port between a coin source (master) and the encoder (slave).
interface coin_stream_encoder_if #(
    parameter int COIN_BITS = coin_pkg::COIN_BITS_DEFAULT
);
    // Transfer on any rising edge with coin_valid && coin_ready; the master holds
    // coin_value stable while coin_valid is high and coin_ready is low.
    logic                 coin_valid;
    logic [COIN_BITS-1:0] coin_value;
    logic                 coin_ready;

    modport master (output coin_valid, output coin_value, input coin_ready);
    modport slave  (input coin_valid, input coin_value, output coin_ready);
endinterface

// File: rtl/coin_fifo.sv
// Synchronous FIFO for coin codes; head is visible on o_head while non-empty, reset flushes it.
module coin_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_head,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_full,
    output logic                           o_empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/coin_stream_encoder.sv
// Buffers coin codes and serializes each as a framed word on x: start, data LSB first,
// optional even parity (COIN_ENC_PARITY_EN), then an idle-low gap.
module coin_stream_encoder
    import coin_pkg::*;
#(
    parameter int COIN_BITS  = COIN_BITS_DEFAULT,
    parameter int BIT_CYCLES = 1,
    parameter int IDLE_GAP   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    coin_stream_encoder_if.slave                coin,
    output logic                                x,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                illegal,
    output coin_state_e                         dbg_state
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CYC_MAX = (BIT_CYCLES > IDLE_GAP) ? BIT_CYCLES : IDLE_GAP;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int BIT_W   = (COIN_BITS > 1) ? $clog2(COIN_BITS) : 1;
    localparam logic [CYC_W-1:0] BC_LAST  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] GAP_LAST = CYC_W'(IDLE_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(COIN_BITS - 1);

    coin_state_e          r_state, w_state_next;
    logic [CYC_W-1:0]     r_cyc, w_cyc_next;
    logic [BIT_W-1:0]     r_bit, w_bit_next;
    logic [COIN_BITS-1:0] r_shift, w_shift_next;
    logic                 r_x, w_x_next;
    logic                 r_illegal;
    logic                 w_accept, w_push, w_pop, w_is_none;
    logic                 w_fifo_full, w_fifo_empty;
    logic [COIN_BITS-1:0] w_fifo_head;
    logic [CNT_W-1:0]     w_fifo_count;
`ifdef COIN_ENC_PARITY_EN
    logic                 r_parity, w_parity_next;
`endif

    assign coin.coin_ready = !reset && !w_fifo_full;
    assign w_accept        = coin.coin_valid && coin.coin_ready;
    assign w_is_none       = (coin.coin_value == COIN_BITS'(COIN_NONE));
    assign w_push          = w_accept && !w_is_none;

    coin_fifo #(
        .WIDTH (COIN_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (coin.coin_value),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // x is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cyc     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_x       <= 1'b0;
            r_illegal <= 1'b0;
`ifdef COIN_ENC_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_cyc     <= w_cyc_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_x       <= w_x_next;
            r_illegal <= w_accept && w_is_none;
`ifdef COIN_ENC_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cyc_next    = r_cyc + CYC_W'(1);
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_x_next      = 1'b0;
        w_pop         = 1'b0;
`ifdef COIN_ENC_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_cyc_next = '0;
                w_bit_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_head;
`ifdef COIN_ENC_PARITY_EN
                    w_parity_next = ^w_fifo_head;
`endif
                    w_state_next = START;
                end
            end
            START: begin
                w_x_next = 1'b1;
                if (r_cyc == BC_LAST) begin
                    w_cyc_next   = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                w_x_next = r_shift[0];
                if (r_cyc == BC_LAST) begin
                    w_cyc_next   = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
                        w_bit_next   = '0;
`ifdef COIN_ENC_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = GAP;
`endif
                    end else begin
                        w_bit_next = r_bit + BIT_W'(1);
                    end
                end
            end
`ifdef COIN_ENC_PARITY_EN
            PARITY: begin
                w_x_next = r_parity;
                if (r_cyc == BC_LAST) begin
                    w_cyc_next   = '0;
                    w_state_next = GAP;
                end
            end
`endif
            GAP: begin
                if (r_cyc == GAP_LAST) begin
                    w_cyc_next   = '0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_cyc_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign x          = r_x;
    assign illegal    = r_illegal;
    assign fifo_count = w_fifo_count;
    assign busy       = (r_state != IDLE) || (w_fifo_count != '0);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_coin_stream_encoder.sv
// Self-checking bench for coin_stream_encoder against a frame-schedule reference model.
module tb_coin_stream_encoder;
    import coin_pkg::*;

`ifdef COIN_ENC_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int MAXC  = 4096;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_a, rst_b;
    logic sel;

    logic        a_x, a_busy, a_ill, b_x, b_busy, b_ill;
    logic [2:0]  a_cnt, b_cnt;
    coin_state_e a_state, b_state;

    coin_stream_encoder_if #(.COIN_BITS(2)) a_if ();
    coin_stream_encoder_if #(.COIN_BITS(2)) b_if ();

    coin_stream_encoder #(.COIN_BITS(2), .BIT_CYCLES(1), .IDLE_GAP(2), .FIFO_DEPTH(DEPTH)) dut_a (
        .clock(clk), .reset(rst_a), .coin(a_if.slave), .x(a_x), .busy(a_busy),
        .fifo_count(a_cnt), .illegal(a_ill), .dbg_state(a_state));

    coin_stream_encoder #(.COIN_BITS(2), .BIT_CYCLES(3), .IDLE_GAP(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .clock(clk), .reset(rst_b), .coin(b_if.slave), .x(b_x), .busy(b_busy),
        .fifo_count(b_cnt), .illegal(b_ill), .dbg_state(b_state));

    // Observed outputs of whichever encoder the current test drives.
    logic        o_x, o_busy, o_ill, o_rdy;
    logic [2:0]  o_cnt;
    coin_state_e o_state;
    assign o_x     = sel ? b_x : a_x;
    assign o_busy  = sel ? b_busy : a_busy;
    assign o_ill   = sel ? b_ill : a_ill;
    assign o_rdy   = sel ? b_if.coin_ready : a_if.coin_ready;
    assign o_cnt   = sel ? b_cnt : a_cnt;
    assign o_state = sel ? b_state : a_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp, n_fail;
    int cyc, next_pop, busy_until;
    int m_bc, m_ig, m_fl;
    logic [1:0] exp_q[$];
    logic x_sched [MAXC];
    logic e_x, e_busy, e_ill, e_rdy, last_acc;
    logic [2:0] e_cnt;

    task automatic set_params(input logic s);
        sel  = s;
        m_bc = s ? 3 : 1;
        m_ig = 2;
        m_fl = (1 + 2 + P) * m_bc;
    endtask

    // One clock: drive inputs, advance the reference model over the edge, sample at negedge.
    task automatic step(input logic rst, input logic v, input logic [1:0] code);
        logic acc, pop;
        logic [1:0] pc;
        if (sel) begin
            rst_b = rst; b_if.coin_valid = v; b_if.coin_value = code;
        end else begin
            rst_a = rst; a_if.coin_valid = v; a_if.coin_value = code;
        end
        acc = !rst && v && (exp_q.size() < DEPTH);
        pop = !rst && (exp_q.size() > 0) && (cyc >= next_pop);
        e_ill = 1'b0;
        if (rst) begin
            exp_q.delete();
            busy_until = -1;
            next_pop   = 0;
            for (int k = cyc; k < MAXC; k++) x_sched[k] = 1'b0;
        end else begin
            if (pop) begin
                pc = exp_q.pop_front();
                for (int k = 0; k < m_fl; k++) begin
                    int f;
                    logic b;
                    f = k / m_bc;
                    if (f == 0) b = 1'b1;
                    else if (f <= 2) b = pc[f-1];
                    else b = ^pc;
                    if (cyc + 1 + k < MAXC) x_sched[cyc+1+k] = b;
                end
                busy_until = cyc + m_fl + m_ig - 1;
                next_pop   = cyc + m_fl + m_ig + 1;
            end
            if (acc && code != COIN_NONE) exp_q.push_back(code);
            e_ill = acc && (code == COIN_NONE);
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        e_x    = x_sched[cyc];
        e_cnt  = 3'(exp_q.size());
        e_busy = (cyc <= busy_until) || (exp_q.size() != 0);
        e_rdy  = !rst && (exp_q.size() < DEPTH);
        cyc++;
    endtask

    task automatic test_reset();
        set_params(1'b0);
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'd0);
            n_cmp++; if (o_x !== 1'b0) begin n_fail++; $display("FAIL reset_x cyc=%0d got=%0b exp=0", cyc, o_x); end
            n_cmp++; if (o_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", cyc, o_cnt); end
            n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc=%0d got=%0b exp=0", cyc, o_busy); end
            n_cmp++; if (o_ill !== 1'b0) begin n_fail++; $display("FAIL reset_illegal cyc=%0d got=%0b exp=0", cyc, o_ill); end
            n_cmp++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready cyc=%0d got=%0b exp=0", cyc, o_rdy); end
            n_cmp++; if (o_state !== IDLE) begin n_fail++; $display("FAIL reset_state cyc=%0d got=%0d exp=%0d", cyc, o_state, IDLE); end
        end
        step(1'b0, 1'b0, 2'd0);
        n_cmp++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL release_ready cyc=%0d got=%0b exp=1", cyc, o_rdy); end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 11; i++) begin
            step(1'b0, i == 0, 2'b10);
            n_cmp++; if (o_x !== e_x) begin n_fail++; $display("FAIL single_x cyc=%0d got=%0b exp=%0b", cyc, o_x, e_x); end
            n_cmp++; if (o_cnt !== e_cnt) begin n_fail++; $display("FAIL single_cnt cyc=%0d got=%0d exp=%0d", cyc, o_cnt, e_cnt); end
            n_cmp++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL single_busy cyc=%0d got=%0b exp=%0b", cyc, o_busy, e_busy); end
            n_cmp++; if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL single_ready cyc=%0d got=%0b exp=%0b", cyc, o_rdy, e_rdy); end
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, i == 0, COIN_NONE);
            n_cmp++; if (o_ill !== e_ill) begin n_fail++; $display("FAIL illegal_pulse cyc=%0d got=%0b exp=%0b", cyc, o_ill, e_ill); end
            n_cmp++; if (o_cnt !== e_cnt) begin n_fail++; $display("FAIL illegal_cnt cyc=%0d got=%0d exp=%0d", cyc, o_cnt, e_cnt); end
            n_cmp++; if (o_x !== e_x) begin n_fail++; $display("FAIL illegal_x cyc=%0d got=%0b exp=%0b", cyc, o_x, e_x); end
            n_cmp++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL illegal_busy cyc=%0d got=%0b exp=%0b", cyc, o_busy, e_busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [6];
        logic [1:0] c;
        int idx;
        seq = '{COIN_25, COIN_50, COIN_100, COIN_25, COIN_50, COIN_100};
        idx = 0;
        for (int t = 0; t < 200 && (idx < 6 || e_busy); t++) begin
            c = (idx < 6) ? seq[idx] : 2'd0;
            step(1'b0, idx < 6, c);
            if (last_acc) idx++;
            n_cmp++; if (o_x !== e_x) begin n_fail++; $display("FAIL b2b_x cyc=%0d got=%0b exp=%0b", cyc, o_x, e_x); end
            n_cmp++; if (o_cnt !== e_cnt) begin n_fail++; $display("FAIL b2b_cnt cyc=%0d got=%0d exp=%0d", cyc, o_cnt, e_cnt); end
            n_cmp++; if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL b2b_ready cyc=%0d got=%0b exp=%0b", cyc, o_rdy, e_rdy); end
            n_cmp++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL b2b_busy cyc=%0d got=%0b exp=%0b", cyc, o_busy, e_busy); end
        end
        n_cmp++;
        if (idx < 6 || e_busy) begin
            n_fail++; $display("FAIL b2b_timeout cyc=%0d accepted=%0d exp=6", cyc, idx);
        end
    endtask

    task automatic test_random();
        logic v;
        logic [1:0] c;
        for (int t = 0; t < 340; t++) begin
            v = (t < 300) && ($urandom_range(0, 3) != 0);
            c = 2'($urandom_range(0, 3));
            step(1'b0, v, c);
            n_cmp++; if (o_x !== e_x) begin n_fail++; $display("FAIL rand_x cyc=%0d got=%0b exp=%0b", cyc, o_x, e_x); end
            n_cmp++; if (o_cnt !== e_cnt) begin n_fail++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, o_cnt, e_cnt); end
            n_cmp++; if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", cyc, o_rdy, e_rdy); end
            n_cmp++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", cyc, o_busy, e_busy); end
            n_cmp++; if (o_ill !== e_ill) begin n_fail++; $display("FAIL rand_illegal cyc=%0d got=%0b exp=%0b", cyc, o_ill, e_ill); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic r, v;
        logic [1:0] c;
        rst_a = 1'b1;
        a_if.coin_valid = 1'b0;
        set_params(1'b1);
        // 2 reset, 2 accepts, 4 idle (into the first data bit), reset, then idle.
        for (int t = 0; t < 30; t++) begin
            r = (t < 2) || (t == 8);
            v = (t == 2) || (t == 3);
            c = (t == 2) ? COIN_25 : COIN_50;
            step(r, v, c);
            n_cmp++; if (o_x !== e_x) begin n_fail++; $display("FAIL midrst_x cyc=%0d got=%0b exp=%0b", cyc, o_x, e_x); end
            n_cmp++; if (o_cnt !== e_cnt) begin n_fail++; $display("FAIL midrst_cnt cyc=%0d got=%0d exp=%0d", cyc, o_cnt, e_cnt); end
            n_cmp++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL midrst_busy cyc=%0d got=%0b exp=%0b", cyc, o_busy, e_busy); end
            n_cmp++; if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL midrst_ready cyc=%0d got=%0b exp=%0b", cyc, o_rdy, e_rdy); end
            if (t == 8) begin
                n_cmp++; if (o_state !== IDLE) begin n_fail++; $display("FAIL midrst_state cyc=%0d got=%0d exp=%0d", cyc, o_state, IDLE); end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; next_pop = 0; busy_until = -1;
        e_busy = 1'b0; last_acc = 1'b0;
        for (int k = 0; k < MAXC; k++) x_sched[k] = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
        a_if.coin_valid = 1'b0; a_if.coin_value = 2'd0;
        b_if.coin_valid = 1'b0; b_if.coin_value = 2'd0;
        test_reset();
        test_single_frame();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
